// File: rtl/wb_sequencer_pkg.sv
// Shared source codes and FSM encodings for the register-file write-back path.
// The write-data mux and the control unit use the same SEL_* codes.
package wb_sequencer_pkg;

  localparam logic [3:0] SEL_ALU   = 4'd0;
  localparam logic [3:0] SEL_LOAD  = 4'd1;
  localparam logic [3:0] SEL_LI    = 4'd2;
  localparam logic [3:0] SEL_MOV   = 4'd3;
  localparam logic [3:0] SEL_MFHI  = 4'd4;
  localparam logic [3:0] SEL_MFLO  = 4'd5;
  localparam logic [3:0] SEL_IN    = 4'd6;
  localparam logic [3:0] SEL_GETPC = 4'd7;
  localparam logic [3:0] SEL_BIOS  = 4'd8;
  localparam logic [3:0] SEL_LAST  = SEL_BIOS;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_MEM  = 3'd1;
  localparam logic [2:0] ST_WAIT_IN   = 3'd2;
  localparam logic [2:0] ST_WAIT_BIOS = 3'd3;
  localparam logic [2:0] ST_WRITE     = 3'd4;

  function automatic logic sel_is_legal(input logic [3:0] sel);
    return sel <= SEL_LAST;
  endfunction

  // Sources that cannot deliver data in the cycle after issue.
  function automatic logic sel_is_slow(input logic [3:0] sel);
    return (sel == SEL_LOAD) || (sel == SEL_IN) || (sel == SEL_BIOS);
  endfunction

endpackage

// File: rtl/wb_edge_detect.sv
// Rising-edge detector: compares the live level against the previous-cycle
// sample, which is refreshed every cycle regardless of who consumes the edge.
module wb_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: the single owner of the register-file write enable.
// Holds the pipe while a slow source is pending, then writes for one cycle.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int BIOS_TIMEOUT = 255,
  parameter int ADDR_W       = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_issue,
  input  logic              i_wb_en,
  input  logic [3:0]        i_wb_sel,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic              i_in_confirm,
  input  logic              i_bios_ready,
  output logic [3:0]        o_write_d_sel,
  output logic [ADDR_W-1:0] o_write_addr,
  output logic              o_reg_write,
  output logic              o_stall,
  output logic              o_in_wait,
  output logic              o_err,
  output logic [2:0]        o_dbg_state
);

  localparam int               BIOS_CNT_W = $clog2(BIOS_TIMEOUT + 1);
  localparam logic [3:0]       MEM_INIT   = 4'(MEM_LAT - 1);
  localparam logic [BIOS_CNT_W-1:0] BIOS_LAST = BIOS_CNT_W'(BIOS_TIMEOUT - 1);

  logic [2:0]            r_state;
  logic [3:0]            r_mem_cnt;
  logic [BIOS_CNT_W-1:0] r_bios_cnt;
  logic [3:0]            r_sel;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_waiting;
  logic                  w_rise;

  // Handshake: issue&wb_en is a one-cycle offer with no ready return; the
  // request is taken only in IDLE/WRITE, and stall is the only backpressure,
  // asserted combinationally in the issue cycle of a slow source.
  assign w_accept  = i_issue & i_wb_en & ((r_state == ST_IDLE) | (r_state == ST_WRITE));
  assign w_waiting = (r_state == ST_WAIT_MEM) | (r_state == ST_WAIT_IN) |
                     (r_state == ST_WAIT_BIOS);

  wb_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_in_confirm),
    .o_rise  (w_rise)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_mem_cnt  <= '0;
      r_bios_cnt <= '0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        r_sel  <= i_wb_sel;
        r_addr <= i_wb_addr;
      end
      case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (!w_accept) begin
            r_state <= ST_IDLE;
          end else if (!sel_is_legal(i_wb_sel)) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            case (i_wb_sel)
              SEL_LOAD: begin
                r_state   <= ST_WAIT_MEM;
                r_mem_cnt <= MEM_INIT;
              end
              SEL_IN:   r_state <= ST_WAIT_IN;
              SEL_BIOS: begin
                r_state    <= ST_WAIT_BIOS;
                r_bios_cnt <= '0;
              end
              default:  r_state <= ST_WRITE;
            endcase
          end
        end
        ST_WAIT_MEM: begin
          if (r_mem_cnt == 4'd0) r_state   <= ST_WRITE;
          else                   r_mem_cnt <= r_mem_cnt - 4'd1;
        end
        ST_WAIT_IN: begin
          if (w_rise) r_state <= ST_WRITE;
        end
        ST_WAIT_BIOS: begin
          // Data arriving on the last allowed cycle still wins over the abort.
          if (i_bios_ready) begin
            r_state <= ST_WRITE;
          end else if (r_bios_cnt == BIOS_LAST) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_bios_cnt <= r_bios_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_write_d_sel = r_sel;
  assign o_write_addr  = r_addr;
  assign o_reg_write   = (r_state == ST_WRITE) && (r_addr != '0);
  assign o_stall       = w_waiting | (w_accept & sel_is_slow(i_wb_sel));
  assign o_in_wait     = (r_state == ST_WAIT_IN);
  assign o_err         = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios with literal expectations, then
// random traffic compared every cycle against a timing-based reference model.
module tb_wb_sequencer;
  import wb_sequencer_pkg::*;

  localparam int MEM_LAT      = 2;
  localparam int BIOS_TIMEOUT = 4;
  localparam int ADDR_W       = 5;
  localparam int W            = 4 + ADDR_W;

  localparam int K_NONE = 0;
  localparam int K_MEM  = 1;
  localparam int K_IN   = 2;
  localparam int K_BIOS = 3;

  logic              clk;
  logic              reset;
  logic              issue;
  logic              wb_en;
  logic [3:0]        wb_sel;
  logic [ADDR_W-1:0] wb_addr;
  logic              in_confirm;
  logic              bios_ready;
  logic [3:0]        write_d_sel;
  logic [ADDR_W-1:0] write_addr;
  logic              reg_write;
  logic              stall;
  logic              in_wait;
  logic              err;
  logic [2:0]        dbg_state;

  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_sequencer #(
    .MEM_LAT      (MEM_LAT),
    .BIOS_TIMEOUT (BIOS_TIMEOUT),
    .ADDR_W       (ADDR_W)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_issue       (issue),
    .i_wb_en       (wb_en),
    .i_wb_sel      (wb_sel),
    .i_wb_addr     (wb_addr),
    .i_in_confirm  (in_confirm),
    .i_bios_ready  (bios_ready),
    .o_write_d_sel (write_d_sel),
    .o_write_addr  (write_addr),
    .o_reg_write   (reg_write),
    .o_stall       (stall),
    .o_in_wait     (in_wait),
    .o_err         (err),
    .o_dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic iss, input logic en, input logic [3:0] s,
                      input logic [ADDR_W-1:0] a, input logic conf, input logic rdy);
    @(posedge clk);
    #1;
    reset      = r;
    issue      = iss;
    wb_en      = en;
    wb_sel     = s;
    wb_addr    = a;
    in_confirm = conf;
    bios_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input logic conf);
    step(1'b0, 1'b0, 1'b0, 4'd0, '0, conf, 1'b0);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The model tracks which slow source is pending and when its wait began;
  // write timing follows from cycle arithmetic against MEM_LAT/BIOS_TIMEOUT.
  int                cyc;
  bit                m_valid;
  int                m_kind;
  int                m_start;
  bit                m_write;
  bit                m_err;
  bit                m_prev;
  logic [3:0]        m_sel;
  logic [ADDR_W-1:0] m_addr;
  logic [W-1:0]      exp_q[$];

  initial begin
    cyc = 0; m_valid = 0; m_kind = K_NONE; m_start = 0;
    m_write = 0; m_err = 0; m_prev = 0; m_sel = '0; m_addr = '0;
  end

  always @(negedge clk) begin
    logic [2:0] e_state;
    bit         take;
    bit         e_stall;
    bit         nxt_write;
    bit         nxt_err;
    logic [W-1:0] rec;
    take = issue && wb_en && (m_kind == K_NONE);
    if (m_valid) begin
      case (m_kind)
        K_MEM:   e_state = ST_WAIT_MEM;
        K_IN:    e_state = ST_WAIT_IN;
        K_BIOS:  e_state = ST_WAIT_BIOS;
        default: e_state = m_write ? ST_WRITE : ST_IDLE;
      endcase
      e_stall = (m_kind != K_NONE) ||
                (take && (wb_sel == 4'd1 || wb_sel == 4'd6 || wb_sel == 4'd8));
      check("m_state",     32'(dbg_state),   32'(e_state));
      check("m_reg_write", 32'(reg_write),   32'(m_write && (m_addr != 0)));
      check("m_sel",       32'(write_d_sel), 32'(m_sel));
      check("m_addr",      32'(write_addr),  32'(m_addr));
      check("m_stall",     32'(stall),       32'(e_stall));
      check("m_in_wait",   32'(in_wait),     32'(m_kind == K_IN));
      check("m_err",       32'(err),         32'(m_err));
      if (reg_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_write", 32'({write_d_sel, write_addr}), 32'h0);
        end else begin
          rec = exp_q.pop_front();
          check("sb_write_rec", 32'({write_d_sel, write_addr}), 32'(rec));
        end
      end
    end
    nxt_write = 0;
    nxt_err   = 0;
    if (reset) begin
      m_valid = 1; m_kind = K_NONE; m_sel = '0; m_addr = '0; m_prev = 0;
      exp_q.delete();
    end else if (m_valid) begin
      case (m_kind)
        K_NONE: if (take) begin
          m_sel  = wb_sel;
          m_addr = wb_addr;
          m_start = cyc + 1;
          if (wb_sel > 4'd8)       nxt_err = 1;
          else if (wb_sel == 4'd1) m_kind = K_MEM;
          else if (wb_sel == 4'd6) m_kind = K_IN;
          else if (wb_sel == 4'd8) m_kind = K_BIOS;
          else                     nxt_write = 1;
        end
        K_MEM: if (cyc - m_start == MEM_LAT - 1) begin
          m_kind = K_NONE; nxt_write = 1;
        end
        K_IN: if (in_confirm && !m_prev) begin
          m_kind = K_NONE; nxt_write = 1;
        end
        K_BIOS: begin
          if (bios_ready) begin
            m_kind = K_NONE; nxt_write = 1;
          end else if (cyc - m_start + 1 == BIOS_TIMEOUT) begin
            m_kind = K_NONE; nxt_err = 1;
          end
        end
        default: m_kind = K_NONE;
      endcase
      m_prev = in_confirm;
    end
    m_write = nxt_write && !reset;
    m_err   = nxt_err && !reset;
    if (m_write && m_addr != 0) exp_q.push_back({m_sel, m_addr});
    cyc++;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1; issue = 0; wb_en = 0; wb_sel = '0; wb_addr = '0;
    in_confirm = 0; bios_ready = 0;
    step(1, 0, 0, 4'd0, '0, 0, 0);
    step(1, 0, 0, 4'd0, '0, 0, 0);
    idle(0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_outs",  32'({write_d_sel, write_addr, reg_write, stall, in_wait, err}), 32'h0);

    // Three back-to-back ALU writes to r3.
    step(0, 1, 1, SEL_ALU, 5'd3, 0, 0);
    check("alu_t0_rw", 32'(reg_write), 32'h0);
    check("alu_t0_stall", 32'(stall), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, SEL_ALU, 5'd3, 0, 0);
      check("alu_rw", 32'(reg_write), 32'h1);
      check("alu_stall", 32'(stall), 32'h0);
    end
    idle(0);
    check("alu_last_rw", 32'(reg_write), 32'h1);
    check("alu_addr", 32'(write_addr), 32'h3);
    idle(0);
    check("alu_done_rw", 32'(reg_write), 32'h0);

    // LOAD to r7 with MEM_LAT=2: stall t..t+2, write at t+3.
    step(0, 1, 1, SEL_LOAD, 5'd7, 0, 0);
    check("ld_t0_stall", 32'(stall), 32'h1);
    for (int i = 1; i <= 2; i++) begin
      idle(0);
      check("ld_wait_stall", 32'(stall), 32'h1);
      check("ld_wait_rw", 32'(reg_write), 32'h0);
    end
    idle(0);
    check("ld_t3_rw", 32'(reg_write), 32'h1);
    check("ld_t3_sel", 32'(write_d_sel), 32'h1);
    check("ld_t3_addr", 32'(write_addr), 32'h7);
    check("ld_t3_stall", 32'(stall), 32'h0);
    idle(0);
    check("ld_t4_rw", 32'(reg_write), 32'h0);

    // IN with in_confirm already high: only a fresh rising edge releases it.
    idle(1);
    step(0, 1, 1, SEL_IN, 5'd5, 1, 0);
    check("in_t0_stall", 32'(stall), 32'h1);
    idle(1);
    check("in_wait_hi", 32'(in_wait), 32'h1);
    idle(1);
    check("in_held_rw", 32'(reg_write), 32'h0);
    idle(0);
    check("in_low_wait", 32'(in_wait), 32'h1);
    idle(1);
    check("in_edge_wait", 32'(in_wait), 32'h1);
    idle(1);
    check("in_write_rw", 32'(reg_write), 32'h1);
    check("in_write_wait", 32'(in_wait), 32'h0);
    check("in_write_addr", 32'(write_addr), 32'h5);

    // BIOS never ready, BIOS_TIMEOUT=4.
    step(0, 1, 1, SEL_BIOS, 5'd9, 0, 0);
    for (int i = 1; i <= BIOS_TIMEOUT; i++) begin
      idle(0);
      check("bios_wait_stall", 32'(stall), 32'h1);
      check("bios_wait_err", 32'(err), 32'h0);
    end
    idle(0);
    check("bios_to_err", 32'(err), 32'h1);
    check("bios_to_stall", 32'(stall), 32'h0);
    check("bios_to_rw", 32'(reg_write), 32'h0);
    idle(0);
    check("bios_err_pulse", 32'(err), 32'h0);

    // Illegal source, then MOV to r0.
    step(0, 1, 1, 4'd12, 5'd4, 0, 0);
    check("ill_t0_err", 32'(err), 32'h0);
    idle(0);
    check("ill_t1_err", 32'(err), 32'h1);
    check("ill_t1_rw", 32'(reg_write), 32'h0);
    idle(0);
    check("ill_t2_err", 32'(err), 32'h0);
    step(0, 1, 1, SEL_MOV, 5'd0, 0, 0);
    idle(0);
    check("r0_state", 32'(dbg_state), 32'(ST_WRITE));
    check("r0_rw", 32'(reg_write), 32'h0);

    // Reset while a LOAD is waiting.
    step(0, 1, 1, SEL_LOAD, 5'd7, 0, 0);
    step(1, 0, 0, 4'd0, '0, 0, 0);
    check("rst_mid_wait", 32'(dbg_state), 32'(ST_WAIT_MEM));
    idle(0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mid_outs", 32'({write_d_sel, write_addr, reg_write, stall, in_wait, err}), 32'h0);
    idle(0);
    idle(0);
    check("rst_mid_nowrite", 32'(reg_write), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] s;
      logic       conf;
      s = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      conf = ($urandom_range(0, 3) == 0) ? ~in_confirm : in_confirm;
      step(($urandom_range(0, 149) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) != 0, s, ADDR_W'($urandom_range(0, 31)),
           conf, $urandom_range(0, 5) == 0);
    end
    idle(0);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Write-back controller for the register-file write port.
- Accepts one write-back request per instruction and drives the write-data source select for the write-data mux.
- Holds the pipeline while a slow source (memory read, user input, BIOS) is pending, then issues a single-cycle register write.
- Sits between the control unit and the register file; it is the only driver of the register write enable.

Parameters:
- MEM_LAT, 2, wait cycles between a LOAD issue and valid read data (legal range 1..15).
- BIOS_TIMEOUT, 255, maximum cycles waiting for bios_ready before aborting.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- issue  input  1  one-cycle pulse: new write-back request
- wb_en  input  1  instruction writes a register (qualifies issue)
- wb_sel  input  4  source code, registered into write_d_sel
- wb_addr  input  ADDR_W  destination register
- in_confirm  input  1  user input-confirm switch, level, already synchronized
- bios_ready  input  1  BIOS data valid, level
- write_d_sel  output  4  source select to the write-data mux
- write_addr  output  ADDR_W  register-file write address
- reg_write  output  1  register-file write enable
- stall  output  1  freeze fetch/decode
- in_wait  output  1  waiting for user input (drives an LED)
- err  output  1  one-cycle pulse on illegal source or BIOS timeout

Behaviour:
- Source codes: 0 ALU, 1 LOAD, 2 LI, 3 MOV, 4 MFHI, 5 MFLO, 6 IN, 7 GETPC, 8 BIOS; 9..15 illegal.
- States: IDLE, WAIT_MEM, WAIT_IN, WAIT_BIOS, WRITE.
- Reset values: state IDLE, write_d_sel 0, write_addr 0, reg_write 0, stall 0, in_wait 0, err 0, counters 0.
- Acceptance: issue&wb_en is accepted in IDLE or WRITE. On acceptance, write_d_sel and write_addr register wb_sel and wb_addr and stay stable until the next acceptance.
- issue with wb_en=0 is ignored.
- issue while in a WAIT_* state is ignored; the control unit is stalled then.
- Immediate sources (0,2,3,4,5,7): go to WRITE. reg_write=1 in the cycle after issue, so back-to-back issues give one write per cycle.
- LOAD: go to WAIT_MEM and load the counter with MEM_LAT-1. Decrement each cycle; at 0 go to WRITE. reg_write asserts MEM_LAT+1 cycles after issue.
- IN: go to WAIT_IN with in_wait=1.
  - Leave only on a rising edge of in_confirm detected while in WAIT_IN. A level already high on entry does not count; the previous-sample register is updated every cycle.
  - On the edge go to WRITE; in_wait drops in the same cycle as the state change.
- BIOS: go to WAIT_BIOS. Go to WRITE when bios_ready=1.
  - The timeout counter increments each waiting cycle. On reaching BIOS_TIMEOUT: go to IDLE, no write, err=1 for one cycle.
- Illegal source: stay/return to IDLE, no write, err=1 in the cycle after issue.
- WRITE: reg_write=1 for exactly one cycle, except when write_addr==0, where reg_write stays 0 (r0 is protected).
  - Next state is IDLE, or a new accepted request's target state.
- stall = state in WAIT_* OR (issue & wb_en & wb_sel in {1,6,8} while in IDLE/WRITE). The combinational term freezes the pipe in the issue cycle.
- Reset mid-transaction: it is synchronous, so it takes effect at the next edge. Return to IDLE with all outputs cleared and no write.

Decomposition:
- Shared package/header holds:
  - the source codes SEL_ALU..SEL_BIOS, reused by the write-data mux and the control unit
  - the state encodings
  - SEL_LAST=8
- One natural sub-module: wb_edge_detect (registered rising-edge detector for in_confirm, synchronous reset).

Test Plan:
- Reset, then issue ALU (sel 0, addr 3) on three consecutive cycles -> reg_write high on three consecutive cycles with write_addr 3 each, stall never high.
- MEM_LAT=2, issue LOAD addr 7 at cycle t -> stall high at t..t+2, reg_write=1 and write_d_sel=1 at t+3 only.
- Issue IN with in_confirm already high -> stays in WAIT_IN with in_wait=1. Drop in_confirm, raise it -> reg_write one cycle later, in_wait=0.
- Issue BIOS, never assert bios_ready, BIOS_TIMEOUT=4 -> err pulses once, no reg_write, stall released.
- Issue sel 12 -> err one cycle, no write. Issue MOV to addr 0 -> WRITE entered but reg_write stays 0.
- Assert reset during WAIT_MEM -> next cycle all outputs 0 and state IDLE; the pending LOAD never writes.
